// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and data-memory signals around the memory arbiter
interface dmem_arbiter_if #(parameter int AW = 8);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [7:0]    core_wdata;
  logic [7:0]    core_rdata;
  logic          core_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_gnt;
  logic [7:0]    host_rdata;
  logic          host_rvalid;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dat_in;
  logic [7:0]    mem_data;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, host_req, host_we, host_addr, host_wdata, mem_data,
    output core_rdata, core_stall, host_gnt, host_rdata, host_rvalid, mem_wr_en, mem_addr, mem_dat_in
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, host_req, host_we, host_addr, host_wdata, mem_data,
    input  core_rdata, core_stall, host_gnt, host_rdata, host_rvalid, mem_wr_en, mem_addr, mem_dat_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority data memory arbiter with starvation escape and bounded host bursts
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int STARVE_MAX = 8,
  parameter int HOST_BURST = 4
) (
  input logic          clk,
  input logic          start,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {CORE_PRI, HOST_PRI} state_t;
  state_t     state;
  logic [7:0] starve_cnt;
  logic [7:0] burst_cnt;
  logic [7:0] rdata_q;
  logic       rvalid_q;
  logic       core_gnt;
  logic       host_gnt;
  logic       host_rd;
  always_comb begin
    core_gnt = state == CORE_PRI ? bus.core_req : bus.core_req && !bus.host_req;
    host_gnt = state == CORE_PRI ? bus.host_req && !bus.core_req : bus.host_req;
    host_rd  = host_gnt && !bus.host_we;
  end
  assign bus.host_gnt    = host_gnt;
  assign bus.core_stall  = bus.core_req && !core_gnt;
  assign bus.core_rdata  = core_gnt ? bus.mem_data : 8'd0;
  assign bus.mem_wr_en   = host_gnt ? bus.host_we : core_gnt && bus.core_we;
  assign bus.mem_addr    = host_gnt ? bus.host_addr : core_gnt ? bus.core_addr : '0;
  assign bus.mem_dat_in  = host_gnt ? bus.host_wdata : core_gnt ? bus.core_wdata : 8'd0;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  // In HOST_PRI a pending host request is always granted, so !host_req is the only early exit
  always_ff @(posedge clk)
    if (start) begin
      state      <= CORE_PRI;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= host_rd;
      if (host_rd) rdata_q <= bus.mem_data;
      if (state == CORE_PRI) begin
        if (bus.host_req && !host_gnt) begin
          starve_cnt <= starve_cnt == 8'(STARVE_MAX - 1) ? 8'd0 : starve_cnt + 8'd1;
          if (starve_cnt == 8'(STARVE_MAX - 1)) begin
            state     <= HOST_PRI;
            burst_cnt <= '0;
          end
        end else starve_cnt <= '0;
      end else if (!bus.host_req || burst_cnt == 8'(HOST_BURST - 1)) begin
        state     <= CORE_PRI;
        burst_cnt <= '0;
      end else burst_cnt <= burst_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: reference-model bench for dmem_arbiter with directed scenarios
module tb_dmem_arbiter;
  localparam int AW = 8, STARVE_MAX = 8, HOST_BURST = 4;
  logic clk = 1'b0;
  logic start = 1'b1;
  int   n_vec = 0, n_err = 0;
  dmem_arbiter_if #(.AW(AW)) bus ();
  dmem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX), .HOST_BURST(HOST_BURST)) dut (.clk(clk), .start(start), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
  assign bus.mem_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  bit         m_live = 0, m_hostpri = 0, m_rvalid = 0;
  int         m_denied = 0, m_burst = 0;
  logic [7:0] m_rdata = 8'd0;
  logic       cg, hg;
  function automatic logic [1:0] grants();
    logic h;
    h = bus.host_req && (m_hostpri || !bus.core_req);
    return {bus.core_req && !h, h};
  endfunction
  always @(negedge clk) if (m_live) begin
    {cg, hg} = grants();
    check("host_gnt", bus.host_gnt, hg);
    check("core_stall", bus.core_stall, bus.core_req && !cg);
    check("mem_wr_en", bus.mem_wr_en, (cg && bus.core_we) || (hg && bus.host_we));
    check("mem_addr", bus.mem_addr, hg ? bus.host_addr : cg ? bus.core_addr : 8'd0);
    check("mem_dat_in", bus.mem_dat_in, hg ? bus.host_wdata : cg ? bus.core_wdata : 8'd0);
    check("core_rdata", bus.core_rdata, cg ? ref_mem[bus.core_addr] : 8'd0);
    check("host_rvalid", bus.host_rvalid, m_rvalid);
    check("host_rdata", bus.host_rdata, m_rdata);
  end
  always @(posedge clk) begin
    {cg, hg} = grants();
    if (m_live || start) begin
      if (cg && bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
      if (hg && bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
    end
    if (start) begin
      m_live = 1; m_hostpri = 0; m_denied = 0; m_burst = 0; m_rvalid = 0; m_rdata = 8'd0;
    end else begin
      m_rvalid = hg && !bus.host_we;
      if (m_rvalid) m_rdata = ref_mem[bus.host_addr];
      if (!m_hostpri) begin
        m_denied = (bus.host_req && !hg) ? m_denied + 1 : 0;
        if (m_denied == STARVE_MAX) begin m_hostpri = 1; m_denied = 0; m_burst = 0; end
      end else begin
        m_burst = hg ? m_burst + 1 : m_burst;
        if (!bus.host_req || m_burst == HOST_BURST) begin m_hostpri = 0; m_burst = 0; end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic cr, cw, input logic [7:0] ca, cd, input logic hr, hw, input logic [7:0] ha, hd);
    bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
    #2;
  endtask
  bit found;
  initial begin
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step(); step();
    start = 1'b0;
    check("reset_rvalid", bus.host_rvalid, 0);
    check("reset_rdata", bus.host_rdata, 0);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("t6_wr_en", bus.mem_wr_en, 0);
    check("t6_addr", bus.mem_addr, 0);
    check("t6_stall", bus.core_stall, 0);
    check("t6_host_gnt", bus.host_gnt, 0);
    step();
    drive(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    check("t1_wr_en", bus.mem_wr_en, 1);
    check("t1_addr", bus.mem_addr, 16'h10);
    check("t1_stall_w", bus.core_stall, 0);
    step();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    check("t1_rdata", bus.core_rdata, 16'hA5);
    check("t1_stall_r", bus.core_stall, 0);
    step();
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
    check("t2_wr_gnt", bus.host_gnt, 1);
    check("t2_wr_en", bus.mem_wr_en, 1);
    step();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
    check("t2_rd_gnt", bus.host_gnt, 1);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("t2_rvalid", bus.host_rvalid, 1);
    check("t2_rdata", bus.host_rdata, 16'h3C);
    step();
    for (int k = 0; k < 32; k++) begin
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
      check("t3_host_gnt", bus.host_gnt, 16'(k % 12 >= 8));
      check("t3_core_stall", bus.core_stall, 16'(k % 12 >= 8));
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
      check("t4_grant", bus.host_gnt, 1);
      step();
    end
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h20, 8'h00);
    check("t4_stall_now", bus.core_stall, 0);
    check("t4_core_rdata", bus.core_rdata, 16'hA5);
    step();
    drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    check("t4_back_core_pri", bus.host_gnt, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
      found = bus.host_gnt;
    end
    check("t5_burst_seen", 16'(found), 1);
    step();
    drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    start = 1'b1;
    check("t5_grant2", bus.host_gnt, 1);
    check("t5_rvalid_g1", bus.host_rvalid, 1);
    step();
    start = 1'b0;
    check("t5_rvalid", bus.host_rvalid, 0);
    check("t5_rdata", bus.host_rdata, 0);
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
      check("t5_starve_restart", bus.host_gnt, 16'(k == 8));
      step();
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
